pipeline_stall_ctrl: RTL and testbench

//  Consumer of the hazard unit's stall request in the 5-stage RISC pipeline.

---
 rtl/pipeline_stall_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: arbitrates stall/branch/halt/memory-wait into PC and pipeline-register controls
module pipeline_stall_ctrl #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             halt,
    input  logic             resume,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);
    localparam int FL_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    localparam int CS_W = $clog2(MAX_STALL + 1);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t           state_q, state_d;
    logic [FL_W-1:0]  flush_left_q, flush_left_d;
    logic [CS_W-1:0]  consec_q, consec_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall_timeout_q, stall_timeout_d;
    always_comb begin
        state_d         = state_q;
        flush_left_d    = flush_left_q;
        consec_d        = consec_q;
        stall_count_d   = stall_count_q;
        flush_count_d   = flush_count_q;
        stall_timeout_d = stall_timeout_q;
        pc_we           = 1'b0;
        pc_sel_branch   = 1'b0;
        ifid_we         = 1'b0;
        ifid_flush      = 1'b0;
        idex_bubble     = 1'b0;
        pipe_en         = mem_ready;
        halted          = state_q == HALT;
        if (!rst_n) begin
            idex_bubble = 1'b1;
            pipe_en     = 1'b0;
            halted      = 1'b0;
        end else if (!mem_ready) begin
            // memory wait freezes everything, including the stall streak
        end else if (branch_taken) begin
            pc_sel_branch = 1'b1;
            pc_we         = 1'b1;
            ifid_we       = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            halted        = 1'b0;
            consec_d      = '0;
            flush_count_d = &flush_count_q ? flush_count_q : flush_count_q + CNT_W'(1);
            state_d       = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            flush_left_d  = FL_W'(FLUSH_CYCLES - 1);
        end else begin
            consec_d = '0;
            case (state_q)
                RUN: begin
                    if (hazard_stall) begin
                        idex_bubble   = 1'b1;
                        stall_count_d = &stall_count_q ? stall_count_q : stall_count_q + CNT_W'(1);
                        consec_d      = consec_q == CS_W'(MAX_STALL) ? consec_q : consec_q + CS_W'(1);
                        if (consec_d == CS_W'(MAX_STALL)) stall_timeout_d = 1'b1;
                    end else if (halt) begin
                        idex_bubble = 1'b1;
                        state_d     = HALT;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_we        = 1'b1;
                    ifid_we      = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    flush_left_d = flush_left_q - FL_W'(1);
                    if (flush_left_q <= FL_W'(1)) state_d = RUN;
                end
                HALT: begin
                    idex_bubble = 1'b1;
                    if (resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RUN;
            flush_left_q    <= '0;
            consec_q        <= '0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_left_q    <= flush_left_d;
            consec_q        <= consec_d;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end
    assign stall_count   = stall_count_q;
    assign flush_count   = flush_count_q;
    assign stall_timeout = stall_timeout_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed per-cycle vectors checked through a scoreboard queue
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst_n, hazard_stall, branch_taken, halt, resume, mem_ready;
    logic pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble, pipe_en, halted, stall_timeout;
    logic [15:0] stall_count, flush_count;
    logic s_pc_we, s_pc_sel_branch, s_ifid_we, s_ifid_flush, s_idex_bubble, s_pipe_en, s_halted, s_stall_timeout;
    logic [1:0] s_stall_count, s_flush_count;
    typedef struct packed {
        logic [6:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        to;
        logic [1:0]  sat;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    // ctl = {pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble, pipe_en, halted}
    localparam logic [6:0] C_R = 7'b0000100, C_N = 7'b1010010, C_S = 7'b0000110,
                           C_B = 7'b1111110, C_F = 7'b1011110, C_H = 7'b0000111,
                           C_M = 7'b0000000, C_MH = 7'b0000001;
    // in = {rst_n, mem_ready, branch_taken, hazard_stall, halt, resume}
    localparam logic [5:0] I_RST = 6'b010000, I_NOP = 6'b110000, I_STL = 6'b110100,
                           I_BRS = 6'b111100, I_BR = 6'b111000, I_HLT = 6'b110010,
                           I_RES = 6'b110001, I_MW = 6'b100000, I_MWBS = 6'b101100;

    pipeline_stall_ctrl #(.CNT_W(16), .FLUSH_CYCLES(2), .MAX_STALL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .halt(halt), .resume(resume), .mem_ready(mem_ready), .pc_we(pc_we),
        .pc_sel_branch(pc_sel_branch), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_en(pipe_en), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count), .stall_timeout(stall_timeout)
    );
    pipeline_stall_ctrl #(.CNT_W(2), .FLUSH_CYCLES(2), .MAX_STALL(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .halt(halt), .resume(resume), .mem_ready(mem_ready), .pc_we(s_pc_we),
        .pc_sel_branch(s_pc_sel_branch), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .pipe_en(s_pipe_en), .halted(s_halted),
        .stall_count(s_stall_count), .flush_count(s_flush_count), .stall_timeout(s_stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic vec(input logic [5:0] in, input logic [6:0] ctl, input int sc, input int fc, input logic to);
        exp_t e;
        {rst_n, mem_ready, branch_taken, hazard_stall, halt, resume} = in;
        e.ctl = ctl;
        e.sc  = 16'(sc);
        e.fc  = 16'(fc);
        e.to  = to;
        e.sat = sc > 3 ? 2'd3 : 2'(sc);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a.ctl = {pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble, pipe_en, halted};
                a.sc  = stall_count;
                a.fc  = flush_count;
                a.to  = stall_timeout;
                a.sat = s_stall_count;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got ctl=%b sc=%0d fc=%0d to=%b sat=%0d, want ctl=%b sc=%0d fc=%0d to=%b sat=%0d",
                             vectors, $time, a.ctl, a.sc, a.fc, a.to, a.sat, e.ctl, e.sc, e.fc, e.to, e.sat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        {rst_n, mem_ready, branch_taken, hazard_stall, halt, resume} = I_RST;
        @(posedge clk);
        #1;
        vec(I_RST, C_R, 0, 0, 0);
        vec(I_NOP, C_N, 0, 0, 0);
        vec(I_STL, C_S, 0, 0, 0);
        vec(I_NOP, C_N, 1, 0, 0);
        vec(I_STL, C_S, 1, 0, 0);
        vec(I_STL, C_S, 2, 0, 0);
        vec(I_STL, C_S, 3, 0, 0);
        vec(I_STL, C_S, 4, 0, 0);
        vec(I_NOP, C_N, 5, 0, 1);
        vec(I_NOP, C_N, 5, 0, 1);
        vec(I_BRS, C_B, 5, 0, 1);
        vec(I_STL, C_F, 5, 1, 1);
        vec(I_NOP, C_N, 5, 1, 1);
        vec(I_HLT, C_S, 5, 1, 1);
        vec(I_NOP, C_H, 5, 1, 1);
        vec(I_STL, C_H, 5, 1, 1);
        vec(I_NOP, C_H, 5, 1, 1);
        vec(I_BR,  C_B, 5, 1, 1);
        vec(I_NOP, C_F, 5, 2, 1);
        vec(I_NOP, C_N, 5, 2, 1);
        vec(I_HLT, C_S, 5, 2, 1);
        vec(I_RES, C_H, 5, 2, 1);
        vec(I_NOP, C_N, 5, 2, 1);
        vec(I_BR,  C_B, 5, 2, 1);
        vec(I_MW,  C_M, 5, 3, 1);
        vec(I_MWBS, C_M, 5, 3, 1);
        vec(I_NOP, C_F, 5, 3, 1);
        vec(I_NOP, C_N, 5, 3, 1);
        vec(I_HLT, C_S, 5, 3, 1);
        vec(I_MW,  C_MH, 5, 3, 1);
        vec(I_RES, C_H, 5, 3, 1);
        vec(I_NOP, C_N, 5, 3, 1);
        vec(I_RST, C_R, 5, 3, 1);
        vec(I_NOP, C_N, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
